// File: rtl/urv_dm_sequencer.sv
// uRV data-memory sequencer: one single-beat strobe/ack bus cycle per load/store.
// Optional hung-access timeout is enabled with `define URV_DM_TIMEOUT_EN.
module urv_dm_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] x_dm_data_s_i,
  input  logic        w_stall_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_data_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_data_i
);

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        is_load_q;
  logic        flushed_q;
  logic        is_b, is_h, is_w;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d;
  logic        misal_d;
  logic        req;
  logic        to_hit;
  logic        finish;
  logic        fin_err;

  assign req = x_valid_i & (x_load_i | x_store_i);

`ifdef URV_DM_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign to_hit = ({1'b0, to_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES);
`else
  logic unused_to;
  assign to_hit    = 1'b0;
  assign unused_to = ^(16'(TIMEOUT_CYCLES));
`endif

  // ack and err take precedence over an expiring timeout
  assign finish  = bus_ack_i | bus_err_i | to_hit;
  assign fin_err = bus_err_i | (to_hit & ~bus_ack_i);

  // size decode: lane enables, lane-replicated store data, misalignment
  always_comb begin
    is_b    = (x_fun_i == LDST_B) | (x_fun_i == LDST_BU);
    is_h    = (x_fun_i == LDST_H) | (x_fun_i == LDST_HU);
    is_w    = (x_fun_i == LDST_L) | ~(is_b | is_h);
    sel_d   = 4'b0000;
    wdata_d = 32'h0;
    misal_d = 1'b0;
    unique case (1'b1)
      is_b: begin
        sel_d   = 4'b0001 << x_dm_addr_i[1:0];
        wdata_d = {4{x_dm_data_s_i[7:0]}};
      end
      is_h: begin
        sel_d   = x_dm_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{x_dm_data_s_i[15:0]}};
        misal_d = x_dm_addr_i[0];
      end
      is_w: begin
        sel_d   = 4'b1111;
        wdata_d = x_dm_data_s_i;
        misal_d = |x_dm_addr_i[1:0];
      end
      default: ;
    endcase
  end

  // bus-cycle FSM with registered bus and completion outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      is_load_q       <= 1'b0;
      flushed_q       <= 1'b0;
      dm_data_l_o     <= 32'h0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_error_o      <= 1'b0;
      bus_stb_o       <= 1'b0;
      bus_we_o        <= 1'b0;
      bus_addr_o      <= 32'h0;
      bus_sel_o       <= 4'b0000;
      bus_data_o      <= 32'h0;
`ifdef URV_DM_TIMEOUT_EN
      to_cnt          <= 16'h0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            bus_addr_o <= {x_dm_addr_i[31:2], 2'b00};
            bus_sel_o  <= sel_d;
            bus_data_o <= wdata_d;
            bus_we_o   <= x_store_i;
            is_load_q  <= x_load_i;
            flushed_q  <= 1'b0;
`ifdef URV_DM_TIMEOUT_EN
            to_cnt     <= 16'h0;
`endif
            if (misal_d) begin
              dm_error_o      <= 1'b1;
              dm_load_done_o  <= x_load_i;
              dm_store_done_o <= x_store_i;
              state           <= DONE;
            end else begin
              bus_stb_o <= 1'b1;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (finish) begin
            bus_stb_o <= 1'b0;
            if (flushed_q | ~x_valid_i) begin
              state <= IDLE;
            end else begin
              dm_error_o      <= fin_err;
              dm_load_done_o  <= is_load_q;
              dm_store_done_o <= ~is_load_q;
              if (is_load_q & bus_ack_i & ~fin_err)
                dm_data_l_o <= bus_data_i;
              state <= DONE;
            end
          end else begin
`ifdef URV_DM_TIMEOUT_EN
            to_cnt <= to_cnt + 16'd1;
`endif
            if (~x_valid_i)
              flushed_q <= 1'b1;
          end
        end
        DONE: begin
          if (!w_stall_i) begin
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_error_o      <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/urv_dm_sequencer.md
# urv_dm_sequencer

Data-memory bus sequencer for the uRV core: accepts one load or store per instruction from the execute/writeback boundary, runs a single-beat strobe/acknowledge cycle on the data bus, and returns raw load data plus load/store completion flags to the writeback stage. It generates byte lanes and store-data lane replication, and detects misaligned accesses. It also terminates hung accesses with a bus error when the timeout feature is compiled in.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles `bus_stb_o` is held without ack/err before the access is aborted (used only with URV_DM_TIMEOUT_EN); 1..65535.
- clk_i  in  1  core clock, all logic on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- x_valid_i  in  1  instruction in writeback stage is valid.
- x_load_i / x_store_i  in  1  instruction is a load / store (mutually exclusive).
- x_fun_i  in  3  access size/sign code (`LDST_B`, `LDST_BU`, `LDST_H`, `LDST_HU`, `LDST_L` from urv_defs.v).
- x_dm_addr_i  in  32  byte address.
- x_dm_data_s_i  in  32  store data, right-aligned.
- w_stall_i  in  1  global writeback stall; high = instruction does not retire this cycle.
- dm_data_l_o  out  32  raw 32-bit bus word captured on ack (lane extraction done downstream).
- dm_load_done_o / dm_store_done_o  out  1  completion flag for the current load / store.
- dm_error_o  out  1  current access ended with misalign, bus error or timeout.
- bus_stb_o  out  1  access request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word address: {x_dm_addr_i[31:2], 2'b00}.
- bus_sel_o  out  4  byte lane enables.
- bus_data_o  out  32  write data.
- bus_ack_i / bus_err_i  in  1  access completed / failed; sampled only while bus_stb_o=1.
- bus_data_i  in  32  read data, valid with bus_ack_i.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when x_valid_i & (x_load_i | x_store_i), register address, sel, data and we, then:
  - aligned: assert bus_stb_o and go to ACCESS;
  - misaligned (halfword with addr[0]=1, or word with addr[1:0]≠0): no bus cycle, set dm_error_o, go to DONE.
- bus_sel_o: B/BU → 4'b0001<<addr[1:0]; H/HU → addr[1] ? 4'b1100 : 4'b0011; L → 4'b1111.
- bus_data_o: byte → {4{data[7:0]}}; half → {2{data[15:0]}}; word → data.
- ACCESS: hold bus_stb_o, addr, sel, data and we stable until a response:
  - bus_ack_i: capture bus_data_i (loads only), drop stb, go to DONE.
  - bus_err_i: drop stb, set dm_error_o, go to DONE. If ack and err are both high, err wins.
- DONE: assert dm_load_done_o or dm_store_done_o (per the latched op), with dm_error_o if set.
  - w_stall_i=0: the instruction retires; clear the flags and go to IDLE. No new access is accepted that same cycle, so the next access starts no earlier than the following cycle.
  - w_stall_i=1: stay in DONE with the flags and dm_data_l_o held.
- Responses sampled in IDLE or DONE are ignored.
- x_valid_i dropping in ACCESS (pipeline flush): the bus cycle still completes; the result is discarded and the FSM returns to IDLE instead of DONE.

## Timing
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0. Reset asserted mid-access drops bus_stb_o immediately (asynchronously).
- Aligned access with zero-wait ack: request seen in cycle 0 → stb high in cycle 1 → ack sampled in cycle 1 → done high in cycle 2. Total 2-cycle latency; each bus wait state adds 1 cycle.
- Misaligned access: done+error high in cycle 1.
- Done flags are registered outputs, never combinational from bus_ack_i.

## Configuration
- URV_DM_TIMEOUT_EN defined: a 16-bit counter is cleared on ACCESS entry and incremented each ACCESS cycle without ack/err. On reaching TIMEOUT_CYCLES, drop stb, set dm_error_o and go to DONE; a late ack is then ignored.
- Undefined: no counter; ACCESS waits indefinitely for ack/err.

## Test plan
- LDST_B store, data 0x000000A5, addr 0x103 → sel 4'b1000, bus_data 0xA5A5A5A5, we=1; zero-wait ack → dm_store_done_o high exactly 2 cycles after request.
- LDST_L load, addr 0x200, ack after 3 wait states returning 0xDEADBEEF → dm_data_l_o=0xDEADBEEF, dm_load_done_o high 5 cycles after request, stb high for 4 cycles.
- LDST_H load, addr 0x201 → no stb ever; done+error high in cycle 1.
- Bus error on a load, with w_stall_i held high 3 cycles → done+error held 3 cycles, then clear; IDLE after w_stall_i falls.
- URV_DM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → stb drops after 4 ACCESS cycles, error set; an ack 2 cycles later is ignored.
- rst_n_i pulsed low during ACCESS → stb=0 in the same cycle, all outputs 0; a following access completes normally.
